// File: rtl/load_buffer.sv
// Load buffer: queues address-resolved loads in order, issues one aligned word read at a
// time, formats the returned data and broadcasts it to the CDB, honouring kill/resolve.
package load_buffer_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic              valid;
        logic              speculative;
        logic [XLEN-1:0]   address;
        logic [TAG_W-1:0]  rd_tag;
        logic [2:0]        mem_size;
        logic [XLEN-1:0]   NPC;
        logic [XLEN-1:0]   inst;
    } LB_PACKET;

    typedef struct packed {
        logic              valid;
        logic              speculative;
        logic [XLEN-1:0]   value;
        logic [TAG_W-1:0]  rob_tag;
        logic [XLEN-1:0]   NPC;
        logic [XLEN-1:0]   inst;
    } EX_WR_PACKET;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WB    = 2'd2,
        DRAIN = 2'd3
    } lb_state_e;
endpackage

module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int LB_DEPTH = 4,
    parameter int LB_IDX   = $clog2(LB_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  LB_PACKET          lb_packet_in,
    input  logic              kill,
    input  logic              resolve,
    output logic              mem_req_valid,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    output EX_WR_PACKET       lb_output,
    input  logic              cdb_grant,
    output logic              lb_full
);

    localparam int CW = LB_IDX + 1;

    LB_PACKET          slot_q [LB_DEPTH];
    LB_PACKET          slot_d [LB_DEPTH];
    logic [LB_IDX-1:0] head_q, head_d;
    logic [LB_IDX-1:0] tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    lb_state_e         state_q, state_d;
    logic [XLEN-1:0]   data_q, data_d;

    LB_PACKET          head_s;
    logic              head_kill_s;
    logic              push_s;
    logic              pop_s;

    // Extract and extend the selected byte/half/word from an aligned memory word.
    function automatic logic [XLEN-1:0] format_load(
        input logic [2:0]      size,
        input logic [1:0]      offset,
        input logic [XLEN-1:0] data
    );
        logic [XLEN-1:0] shifted;
        logic [7:0]      byte_v;
        logic [15:0]     half_v;
        shifted = data >> {offset, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = offset[1] ? data[31:16] : data[15:0];
        case (size)
            3'b000:  format_load = {{24{byte_v[7]}}, byte_v};
            3'b001:  format_load = {{16{half_v[15]}}, half_v};
            3'b010:  format_load = data;
            3'b100:  format_load = {24'h000000, byte_v};
            3'b101:  format_load = {16'h0000, half_v};
            default: format_load = 32'hfacebeec;
        endcase
    endfunction

    assign head_s      = slot_q[head_q];
    assign head_kill_s = kill & head_s.speculative;
    assign lb_full     = (count_q == CW'(LB_DEPTH));
    assign push_s      = lb_packet_in.valid & ~lb_full;

    // Next-state logic for the queue, the issue/writeback FSM and the memory/CDB outputs.
    always_comb begin
        slot_d        = slot_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        state_d       = state_q;
        data_d        = data_q;
        pop_s         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = {head_s.address[XLEN-1:2], 2'b00};
        lb_output     = '0;

        // Kill takes priority: when both are high the speculative bits survive so kill can act.
        for (int i = 0; i < LB_DEPTH; i++) begin
            slot_d[i].valid       = slot_q[i].valid & ~(kill & slot_q[i].speculative);
            slot_d[i].speculative = slot_q[i].speculative & ~(resolve & ~kill);
        end

        case (state_q)
            IDLE: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                end else if (!head_s.valid) begin
                    pop_s   = 1'b1;
                    state_d = IDLE;
                end else if (!head_kill_s) begin
                    mem_req_valid = 1'b1;
                    state_d       = mem_req_ready ? WAIT : IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (head_kill_s) begin
                    if (mem_resp_valid) begin
                        pop_s   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_resp_valid) begin
                    data_d  = format_load(head_s.mem_size, head_s.address[1:0], mem_resp_data);
                    state_d = WB;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    pop_s   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            WB: begin
                if (head_kill_s) begin
                    pop_s   = 1'b1;
                    state_d = IDLE;
                end else begin
                    lb_output.valid       = 1'b1;
                    lb_output.speculative = head_s.speculative & ~resolve;
                    lb_output.value       = data_q;
                    lb_output.rob_tag     = head_s.rd_tag;
                    lb_output.NPC         = head_s.NPC;
                    lb_output.inst        = head_s.inst;
                    if (cdb_grant) begin
                        pop_s   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_s) begin
            slot_d[tail_q]             = lb_packet_in;
            slot_d[tail_q].valid       = 1'b1;
            slot_d[tail_q].speculative = lb_packet_in.speculative & ~resolve;
            tail_d                     = tail_q + LB_IDX'(1);
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = head_q + LB_IDX'(1);
        end else begin
            head_d = head_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < LB_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            for (int i = 0; i < LB_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: a memory responder model, a CDB scoreboard monitor
// and one task per scenario.
module tb_load_buffer;
    import load_buffer_pkg::*;

    logic              clock;
    logic              reset;
    LB_PACKET          lb_packet_in;
    logic              kill;
    logic              resolve;
    logic              mem_req_valid;
    logic [XLEN-1:0]   mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_data;
    EX_WR_PACKET       lb_output;
    logic              cdb_grant;
    logic              lb_full;

    typedef struct packed {
        logic [31:0] value;
        logic [4:0]  tag;
        logic        spec;
    } exp_t;

    exp_t              exp_q[$];
    logic [31:0]       mem_model [int unsigned];
    int                total;
    int                bad;
    int                resp_delay;
    int                full_offers;

    load_buffer #(.LB_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .lb_packet_in   (lb_packet_in),
        .kill           (kill),
        .resolve        (resolve),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .lb_output      (lb_output),
        .cdb_grant      (cdb_grant),
        .lb_full        (lb_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: accepts a request at the edge, answers resp_delay cycles after the next one.
    initial begin : responder
        logic        hs;
        logic        pending;
        int          cnt;
        logic [31:0] paddr;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        pending        = 1'b0;
        cnt            = 0;
        paddr          = '0;
        forever begin
            @(negedge clock);
            hs = reset && mem_req_valid && mem_req_ready;
            if (!reset) pending = 1'b0;
            if (hs) begin
                pending = 1'b1;
                cnt     = resp_delay;
                paddr   = mem_req_addr;
            end
            @(posedge clock);
            #1;
            mem_resp_valid = 1'b0;
            if (pending) begin
                if (cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_model.exists(paddr) ? mem_model[paddr] : 32'h0;
                    pending        = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
    end

    // CDB scoreboard: every granted broadcast must match the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && lb_packet_in.valid && lb_full) full_offers++;
            if (lb_output.valid && cdb_grant) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL cdb_unexpected: got tag=%0d value=%h, nothing expected",
                             lb_output.rob_tag, lb_output.value);
                end else begin
                    e = exp_q.pop_front();
                    if (lb_output.value !== e.value || lb_output.rob_tag !== e.tag ||
                        lb_output.speculative !== e.spec) begin
                        bad++;
                        $display("FAIL cdb_broadcast: got tag=%0d value=%h spec=%b, want tag=%0d value=%h spec=%b",
                                 lb_output.rob_tag, lb_output.value, lb_output.speculative,
                                 e.tag, e.value, e.spec);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] addr, input logic [4:0] tag,
                        input logic [2:0] size, input logic spec);
        int guard = 0;
        while (lb_full && guard < 50) begin
            tick();
            guard++;
        end
        lb_packet_in             = '0;
        lb_packet_in.valid       = 1'b1;
        lb_packet_in.speculative = spec;
        lb_packet_in.address     = addr;
        lb_packet_in.rd_tag      = tag;
        lb_packet_in.mem_size    = size;
        lb_packet_in.NPC         = addr + 32'd4;
        lb_packet_in.inst        = {17'd0, size, 5'd1, 7'b0000011};
        tick();
        lb_packet_in.valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output logic ok);
        int n = 0;
        while (!(dut.count_q == 0 && dut.state_q == IDLE && exp_q.size() == 0) && n < limit) begin
            @(negedge clock);
            n++;
        end
        ok = (n < limit);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        @(negedge clock);
        total++;
        if (mem_req_valid !== 1'b0 || lb_output !== '0 || lb_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b out_valid=%b full=%b, want 0 0 0",
                     mem_req_valid, lb_output.valid, lb_full);
        end
        total++;
        if (dut.count_q !== 3'd0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got count=%0d state=%0d, want 0 IDLE", dut.count_q, dut.state_q);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_lw_latency();
        mem_model[32'h100] = 32'hDEADBEEF;
        exp_q.push_back({32'hDEADBEEF, 5'd5, 1'b0});
        send(32'h100, 5'd5, 3'b010, 1'b0);
        @(negedge clock);
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
            bad++;
            $display("FAIL lw_request: got valid=%b addr=%h, want 1 00000100", mem_req_valid, mem_req_addr);
        end
        @(negedge clock);
        total++;
        if (lb_output.valid !== 1'b0) begin
            bad++;
            $display("FAIL lw_early_output: got valid=%b in cycle 2, want 0", lb_output.valid);
        end
        @(negedge clock);
        total++;
        if (lb_output.valid !== 1'b1 || lb_output.value !== 32'hDEADBEEF || lb_output.rob_tag !== 5'd5) begin
            bad++;
            $display("FAIL lw_output: got valid=%b value=%h tag=%0d, want 1 deadbeef 5",
                     lb_output.valid, lb_output.value, lb_output.rob_tag);
        end
        @(negedge clock);
        total++;
        if (dut.count_q !== 3'd0) begin
            bad++;
            $display("FAIL lw_count: got %0d, want 0", dut.count_q);
        end
        tick();
    endtask

    task automatic test_format();
        logic ok;
        mem_model[32'h100] = 32'h80FFFF12;
        exp_q.push_back({32'hFFFFFF80, 5'd1, 1'b0});
        exp_q.push_back({32'h00000080, 5'd2, 1'b0});
        exp_q.push_back({32'hFFFF80FF, 5'd3, 1'b0});
        exp_q.push_back({32'h000080FF, 5'd4, 1'b0});
        exp_q.push_back({32'hFACEBEEC, 5'd6, 1'b0});
        send(32'h103, 5'd1, 3'b000, 1'b0);
        send(32'h103, 5'd2, 3'b100, 1'b0);
        send(32'h102, 5'd3, 3'b001, 1'b0);
        send(32'h102, 5'd4, 3'b101, 1'b0);
        send(32'h100, 5'd6, 3'b011, 1'b0);
        wait_idle(300, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL format_drain: got pending=%0d count=%0d, want 0 0", exp_q.size(), dut.count_q);
        end
        tick();
    endtask

    task automatic test_full();
        logic ok;
        full_offers   = 0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_model[32'h200 + 32'(i * 4)] = 32'h11111111 * 32'(i + 1);
            exp_q.push_back({32'h11111111 * 32'(i + 1), 5'(8 + i), 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            send(32'h200 + 32'(i * 4), 5'(8 + i), 3'b010, 1'b0);
        end
        @(negedge clock);
        total++;
        if (lb_full !== 1'b1) begin
            bad++;
            $display("FAIL full_flag: got %b after 4 loads, want 1", lb_full);
        end
        tick();
        lb_packet_in.valid  = 1'b1;
        lb_packet_in.rd_tag = 5'd12;
        lb_packet_in.address = 32'h210;
        tick();
        lb_packet_in.valid = 1'b0;
        total++;
        if (full_offers !== 1) begin
            bad++;
            $display("FAIL full_offer_seen: got %0d offers while full, want 1", full_offers);
        end
        mem_req_ready = 1'b1;
        wait_idle(300, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL full_drain: got pending=%0d count=%0d, want 0 0", exp_q.size(), dut.count_q);
        end
        tick();
    endtask

    task automatic test_kill_skip();
        int   n;
        logic req_b;
        resp_delay = 2;
        mem_model[32'h300] = 32'h33333333;
        mem_model[32'h304] = 32'h44444444;
        exp_q.push_back({32'h33333333, 5'd1, 1'b0});
        send(32'h300, 5'd1, 3'b010, 1'b0);
        send(32'h304, 5'd2, 3'b010, 1'b1);
        n = 0;
        while (dut.state_q !== WAIT && n < 20) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL kill_reach_wait: got state=%0d, want WAIT", dut.state_q);
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        n     = 0;
        req_b = 1'b0;
        while (!(dut.count_q == 0 && dut.state_q == IDLE && exp_q.size() == 0) && n < 100) begin
            @(negedge clock);
            if (mem_req_valid && mem_req_addr == 32'h304) req_b = 1'b1;
            n++;
        end
        total++;
        if (req_b !== 1'b0) begin
            bad++;
            $display("FAIL kill_skip_request: got request for killed load=%b, want 0", req_b);
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL kill_skip_drain: got count=%0d pending=%0d, want 0 0", dut.count_q, exp_q.size());
        end
        resp_delay = 0;
        tick();
    endtask

    task automatic test_drain_resolve();
        int   n;
        logic seen_out;
        logic ok;
        for (int m = 0; m < 2; m++) begin
            resp_delay = 3;
            mem_model[32'h400] = 32'h55667788;
            if (m == 1) exp_q.push_back({32'h55667788, 5'd9, 1'b0});
            send(32'h400, 5'd9, 3'b010, 1'b1);
            n = 0;
            while (dut.state_q !== WAIT && n < 20) begin
                @(negedge clock);
                n++;
            end
            tick();
            if (m == 0) kill = 1'b1;
            else resolve = 1'b1;
            tick();
            kill    = 1'b0;
            resolve = 1'b0;
            @(negedge clock);
            total++;
            if (dut.state_q !== (m == 0 ? DRAIN : WAIT)) begin
                bad++;
                $display("FAIL drain_state_m%0d: got state=%0d, want %0d", m, dut.state_q, (m == 0 ? DRAIN : WAIT));
            end
            seen_out = 1'b0;
            n = 0;
            while (!(dut.count_q == 0 && dut.state_q == IDLE && exp_q.size() == 0) && n < 100) begin
                @(negedge clock);
                if (lb_output.valid) seen_out = 1'b1;
                n++;
            end
            ok = (n < 100);
            total++;
            if (ok !== 1'b1 || seen_out !== (m == 1)) begin
                bad++;
                $display("FAIL drain_outcome_m%0d: got done=%b broadcast=%b, want 1 %b", m, ok, seen_out, (m == 1));
            end
            resp_delay = 0;
            tick();
        end
    endtask

    task automatic test_hold_reset();
        int n;
        cdb_grant = 1'b0;
        mem_model[32'h500] = 32'hCAFEF00D;
        send(32'h500, 5'd7, 3'b010, 1'b0);
        n = 0;
        while (lb_output.valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        tick();
        send(32'h504, 5'd13, 3'b010, 1'b0);
        send(32'h508, 5'd14, 3'b010, 1'b0);
        send(32'h50C, 5'd15, 3'b010, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            total++;
            if (lb_output.valid !== 1'b1 || lb_output.value !== 32'hCAFEF00D || lb_output.rob_tag !== 5'd7) begin
                bad++;
                $display("FAIL hold_stable_%0d: got valid=%b value=%h tag=%0d, want 1 cafef00d 7",
                         k, lb_output.valid, lb_output.value, lb_output.rob_tag);
            end
        end
        total++;
        if (lb_full !== 1'b1) begin
            bad++;
            $display("FAIL hold_full: got %b, want 1", lb_full);
        end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (lb_output !== '0 || lb_full !== 1'b0 || dut.state_q !== IDLE || dut.count_q !== 3'd0) begin
            bad++;
            $display("FAIL midwb_reset: got out_valid=%b full=%b state=%0d count=%0d, want 0 0 IDLE 0",
                     lb_output.valid, lb_full, dut.state_q, dut.count_q);
        end
        cdb_grant = 1'b1;
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        full_offers   = 0;
        resp_delay    = 0;
        reset         = 1'b0;
        kill          = 1'b0;
        resolve       = 1'b0;
        mem_req_ready = 1'b1;
        cdb_grant     = 1'b1;
        lb_packet_in  = '0;
        test_reset();
        test_lw_latency();
        test_format();
        test_full();
        test_kill_skip();
        test_drain_resolve();
        test_hold_reset();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d unbroadcast loads, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
